// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus select encodings and arbiter state codes
package bus_arbiter_pkg;
    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_M1   = 2'b01;
    localparam logic [1:0] SEL_M2   = 2'b10;
    typedef enum logic [1:0] {
        IDLE   = SEL_NONE,
        OWN_M1 = SEL_M1,
        OWN_M2 = SEL_M2
    } state_t;
endpackage

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: clearable tenure counter that saturates at its terminal count
module arb_hold_counter #(
    parameter int         W      = 8,
    parameter logic [W-1:0] TC_VAL = 8'd15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == TC_VAL;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !tc) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with alternating priority, hold-time preemption and locked tenures
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter bit DEFAULT_M1 = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HBUSREQ_1,
    input  logic       HBUSREQ_2,
    input  logic       HLOCK_1,
    input  logic       HLOCK_2,
    input  logic       HREADY,
    output logic       HGRANT_1,
    output logic       HGRANT_2,
    output logic [1:0] SEL,
    output logic       HMASTLOCK
);
    state_t     state, nxt;
    logic       prio_m1, lock_nxt, tc;
    logic [7:0] cnt;
    assign SEL      = state;
    assign HGRANT_1 = state == OWN_M1;
    assign HGRANT_2 = state == OWN_M2;
    always_comb begin
        nxt = state;
        if (HREADY) begin
            unique case (state)
                IDLE:    nxt = (HBUSREQ_1 && (!HBUSREQ_2 || prio_m1)) ? OWN_M1 : HBUSREQ_2 ? OWN_M2 : IDLE;
                OWN_M1:  nxt = !HBUSREQ_1 ? (HBUSREQ_2 ? OWN_M2 : IDLE) :
                               (HBUSREQ_2 && !HLOCK_1 && tc) ? OWN_M2 : OWN_M1;
                OWN_M2:  nxt = !HBUSREQ_2 ? (HBUSREQ_1 ? OWN_M1 : IDLE) :
                               (HBUSREQ_1 && !HLOCK_2 && tc) ? OWN_M1 : OWN_M2;
                default: nxt = IDLE;
            endcase
        end
        lock_nxt = nxt == OWN_M1 ? HLOCK_1 : nxt == OWN_M2 ? HLOCK_2 : 1'b0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            prio_m1   <= DEFAULT_M1;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= nxt;
            prio_m1   <= nxt == OWN_M1 ? 1'b0 : nxt == OWN_M2 ? 1'b1 : prio_m1;
            HMASTLOCK <= lock_nxt;
        end
    end
    arb_hold_counter #(.W(8), .TC_VAL(8'(MAX_HOLD - 1))) u_hold (
        .clk(CLK),
        .rst(RST),
        .clr(HREADY && nxt != state),
        .en (HREADY && state != IDLE),
        .cnt(cnt),
        .tc (tc)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven and directed-sequence checks for bus_arbiter
module tb_bus_arbiter;
    logic       CLK = 1'b0;
    logic       RST, HBUSREQ_1, HBUSREQ_2, HLOCK_1, HLOCK_2, HREADY;
    logic       HGRANT_1, HGRANT_2, HMASTLOCK;
    logic [1:0] SEL;
    int         n_cmp = 0;
    int         n_bad = 0;
    bus_arbiter #(.MAX_HOLD(16), .DEFAULT_M1(1'b1)) dut (
        .CLK(CLK), .RST(RST), .HBUSREQ_1(HBUSREQ_1), .HBUSREQ_2(HBUSREQ_2),
        .HLOCK_1(HLOCK_1), .HLOCK_2(HLOCK_2), .HREADY(HREADY),
        .HGRANT_1(HGRANT_1), .HGRANT_2(HGRANT_2), .SEL(SEL), .HMASTLOCK(HMASTLOCK)
    );
    always #5 CLK = ~CLK;
    typedef struct {
        logic       rst, r1, r2, l1, l2, rdy;
        logic [1:0] sel;
        logic       ml;
    } vec_t;
    vec_t v[18];
    function automatic vec_t mk(input logic rst, r1, r2, l1, l2, rdy, input logic [1:0] sel, input logic ml);
        vec_t t;
        t.rst = rst; t.r1 = r1; t.r2 = r2; t.l1 = l1; t.l2 = l2; t.rdy = rdy; t.sel = sel; t.ml = ml;
        return t;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic drive(input logic rst, r1, r2, l1, l2, rdy);
        RST = rst; HBUSREQ_1 = r1; HBUSREQ_2 = r2; HLOCK_1 = l1; HLOCK_2 = l2; HREADY = rdy;
    endtask
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic check_out(input string nm, input logic [1:0] sel, input logic ml);
        chk({nm, ".sel"}, 32'(SEL), 32'(sel));
        chk({nm, ".g1"}, 32'(HGRANT_1), 32'(sel == 2'b01));
        chk({nm, ".g2"}, 32'(HGRANT_2), 32'(sel == 2'b10));
        chk({nm, ".ml"}, 32'(HMASTLOCK), 32'(ml));
    endtask
    task automatic do_reset;
        drive(1, 0, 0, 0, 0, 1);
        tick;
    endtask
    initial begin
        int n, h, bad;
        v[0]  = mk(1, 0, 0, 0, 0, 1, 2'b00, 0);
        v[1]  = mk(0, 1, 0, 0, 0, 1, 2'b01, 0);
        v[2]  = mk(0, 1, 0, 0, 0, 1, 2'b01, 0);
        v[3]  = mk(0, 0, 0, 0, 0, 1, 2'b00, 0);
        v[4]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 0);
        v[5]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 0);
        v[6]  = mk(0, 1, 0, 0, 0, 1, 2'b01, 0);
        v[7]  = mk(0, 1, 0, 1, 0, 1, 2'b01, 1);
        v[8]  = mk(0, 1, 0, 1, 0, 0, 2'b01, 1);
        v[9]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 1);
        v[10] = mk(0, 0, 0, 0, 0, 1, 2'b00, 0);
        v[11] = mk(0, 0, 1, 0, 0, 1, 2'b10, 0);
        v[12] = mk(0, 0, 1, 0, 1, 1, 2'b10, 1);
        v[13] = mk(1, 0, 1, 0, 1, 0, 2'b00, 0);
        v[14] = mk(0, 1, 1, 0, 0, 0, 2'b00, 0);
        v[15] = mk(0, 1, 1, 0, 0, 1, 2'b01, 0);
        v[16] = mk(0, 0, 1, 0, 0, 1, 2'b10, 0);
        v[17] = mk(0, 0, 0, 0, 0, 1, 2'b00, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick;
        tick;
        for (int i = 0; i < 18; i++) begin
            drive(v[i].rst, v[i].r1, v[i].r2, v[i].l1, v[i].l2, v[i].rdy);
            tick;
            check_out($sformatf("vec%0d", i), v[i].sel, v[i].ml);
        end
        do_reset;
        drive(0, 1, 0, 0, 0, 1);
        tick;
        chk("hold.grant", 32'(SEL), 32'd1);
        drive(0, 1, 1, 0, 0, 1);
        n = 0;
        while (SEL == 2'b01 && n < 100) begin tick; n++; end
        chk("hold.m1_cycles", n, 16);
        chk("hold.to_m2", 32'(SEL), 32'd2);
        n = 0;
        while (SEL == 2'b10 && n < 100) begin tick; n++; end
        chk("hold.m2_cycles", n, 16);
        chk("hold.to_m1", 32'(SEL), 32'd1);
        do_reset;
        drive(0, 1, 0, 1, 0, 1);
        tick;
        drive(0, 1, 1, 1, 0, 1);
        bad = 0;
        repeat (40) begin
            tick;
            if (SEL !== 2'b01 || HMASTLOCK !== 1'b1) bad++;
        end
        chk("lock.held_bad_cycles", bad, 0);
        drive(0, 1, 1, 0, 0, 1);
        tick;
        chk("lock.release_sel", 32'(SEL), 32'd2);
        chk("lock.release_ml", 32'(HMASTLOCK), 32'd0);
        do_reset;
        drive(0, 1, 1, 0, 0, 1);
        tick;
        chk("stall.grant_m1", 32'(SEL), 32'd1);
        drive(0, 0, 1, 0, 0, 0);
        bad = 0;
        repeat (5) begin
            tick;
            if (SEL !== 2'b01 || HGRANT_1 !== 1'b1 || HGRANT_2 !== 1'b0) bad++;
        end
        chk("stall.frozen_bad_cycles", bad, 0);
        drive(0, 0, 1, 0, 0, 1);
        tick;
        chk("stall.handover", 32'(SEL), 32'd2);
        do_reset;
        drive(0, 1, 0, 0, 0, 1);
        tick;
        drive(0, 1, 1, 0, 0, 0);
        h = 0;
        n = 0;
        while (SEL == 2'b01 && n < 200) begin
            HREADY = n[0];
            tick;
            if (n[0]) h++;
            n++;
        end
        chk("gated.hready_edges", h, 16);
        chk("gated.to_m2", 32'(SEL), 32'd2);
        do_reset;
        drive(0, 0, 1, 0, 1, 1);
        tick;
        tick;
        check_out("rst_lock.before", 2'b10, 1'b1);
        drive(1, 0, 1, 0, 1, 1);
        tick;
        check_out("rst_lock.abort", 2'b00, 1'b0);
        drive(0, 0, 1, 0, 1, 1);
        tick;
        check_out("rst_lock.regrant", 2'b10, 1'b1);
        bad = 0;
        repeat (2000) begin
            drive($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 3) != 0);
            tick;
            if ((HGRANT_1 && HGRANT_2) || SEL == 2'b11 ||
                HGRANT_1 !== (SEL == 2'b01) || HGRANT_2 !== (SEL == 2'b10)) bad++;
        end
        chk("stress.invariant_bad_cycles", bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
